// File: rtl/mod2011_chunk_reducer_if.sv
// Operand, result and LUT-bank signals of the mod-2011 chunk reducer.
// master: the reducer itself; slave: operand source, result sink and residue bank.
interface mod2011_chunk_reducer_if #(
  parameter int IN_W    = 500,
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 11,
  parameter int SEL_W   = 7
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic [SEL_W-1:0]   lut_sel;
  logic [CHUNK_W-1:0] lut_x;
  logic [RES_W-1:0]   lut_z;
  logic               out_valid;
  logic               out_ready;
  logic [RES_W-1:0]   out_res;
  logic               busy;
  logic               err;

  modport master (
    input  in_valid, in_data, lut_z, out_ready,
    output in_ready, lut_sel, lut_x, out_valid, out_res, busy, err
  );

  modport slave (
    output in_valid, in_data, lut_z, out_ready,
    input  in_ready, lut_sel, lut_x, out_valid, out_res, busy, err
  );
endinterface

// File: rtl/mod2011_chunk_reducer.sv
// Reduces a wide unsigned operand modulo MOD, one CHUNK_W-bit chunk per cycle,
// using an external positional-residue bank and a single-subtract modular adder.
module mod2011_chunk_reducer #(
  parameter int IN_W    = 500,
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 11,
  parameter int MOD     = 2011
) (
  input  logic clk,
  input  logic rst_n,
  mod2011_chunk_reducer_if.master bus
);
  localparam int NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
  localparam int SEL_W  = $clog2(NCHUNK);
  localparam logic [RES_W:0]   MOD_V  = (RES_W+1)'(MOD);
  localparam logic [SEL_W-1:0] K_LAST = SEL_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [IN_W-1:0]    opr;
  logic [SEL_W-1:0]   k;
  logic [RES_W-1:0]   acc;
  logic               err_q;
  logic [RES_W:0]     sum, sum_red;
  logic               take_in, take_out, last_chunk, z_bad;

  // Modular adder and handshake qualifiers
  always_comb begin
    sum        = {1'b0, acc} + {1'b0, bus.lut_z};
    sum_red    = (sum >= MOD_V) ? (sum - MOD_V) : sum;
    z_bad      = ({1'b0, bus.lut_z} >= MOD_V);
    take_in    = (state == IDLE) && bus.in_valid;
    take_out   = (state == DONE) && bus.out_ready;
    last_chunk = (k == K_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take_in)    state_nx = RUN;
      RUN:     if (last_chunk) state_nx = DONE;
      DONE:    if (take_out)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand shifter, chunk index, accumulator, sticky error.
  // The operand is shifted right one chunk per cycle so the current chunk always
  // sits in the low bits; zero fill supplies the padding of the top chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr   <= '0;
      k     <= '0;
      acc   <= '0;
      err_q <= 1'b0;
    end else if (take_in) begin
      opr   <= bus.in_data;
      k     <= '0;
      acc   <= '0;
      err_q <= 1'b0;
    end else if (state == RUN) begin
      opr <= opr >> CHUNK_W;
      k   <= last_chunk ? '0 : k + SEL_W'(1);
      acc <= sum_red[RES_W-1:0];
      if (z_bad) err_q <= 1'b1;
    end
  end

  // Outputs decoded from state; bank drive is zero outside RUN
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DONE);
    bus.out_res   = (state == DONE) ? acc : '0;
    bus.lut_sel   = (state == RUN) ? k : '0;
    bus.lut_x     = (state == RUN) ? opr[CHUNK_W-1:0] : '0;
    bus.err       = err_q;
  end
endmodule

// File: tb/tb_mod2011_chunk_reducer.sv
// Self-checking bench for mod2011_chunk_reducer: behavioural bank and reference
// model, randomized operands and consumer backpressure, plus pinned literal cases.
module tb_mod2011_chunk_reducer;
  localparam int IN_W = 500;
  localparam int NCH  = 84;
  localparam int M    = 2011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mod2011_chunk_reducer_if #(.IN_W(IN_W), .CHUNK_W(6), .RES_W(11), .SEL_W(7)) bus ();

  mod2011_chunk_reducer #(.IN_W(IN_W), .CHUNK_W(6), .RES_W(11), .MOD(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_chk = 0;
  int n_fail = 0;

  int force_k = -1;
  int lit_sel = -1, lit_x = 0, lit_z = 0, lit_res = -1, lit_err = -1;

  // Bank: weight of chunk k is 2^(6k) mod 2011
  function automatic int bank_fn(int k, int x);
    int w = 1;
    for (int i = 0; i < 6 * k; i++) w = (w * 2) % M;
    return (x * w) % M;
  endfunction

  // Reference residue: plain bit-serial Horner reduction
  function automatic int mod_ref(logic [IN_W-1:0] v);
    int r = 0;
    for (int i = IN_W - 1; i >= 0; i--) r = (r * 2 + int'(v[i])) % M;
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rnd_op();
    logic [IN_W-1:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[IN_W-33:0], 32'($urandom)};
    return v;
  endfunction

  logic [10:0] bank_z;
  always_comb begin
    bank_z = 11'(bank_fn(int'(bus.lut_sel), int'(bus.lut_x)));
    if (force_k >= 0 && int'(bus.lut_sel) == force_k) bank_z = 11'd2047;
  end
  assign bus.lut_z = bank_z;

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: phase 0 idle, 1 running chunk m_cnt, 2 holding result
  int              m_st = 0, m_cnt = 0, m_res = 0;
  bit              m_err = 0, m_known = 1;
  logic [IN_W-1:0] m_op = '0, m_sh;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_cnt = 0;
      chk("rst_out_res", bus.out_res, 0);
      chk("rst_err", bus.err, 0);
    end
    case (m_st)
      0: begin
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_lut_sel", bus.lut_sel, 0);
        chk("idle_lut_x", bus.lut_x, 0);
      end
      1: begin
        m_sh = m_op >> (6 * m_cnt);
        chk("run_in_ready", bus.in_ready, 0);
        chk("run_busy", bus.busy, 1);
        chk("run_out_valid", bus.out_valid, 0);
        chk("run_lut_sel", bus.lut_sel, m_cnt);
        chk("run_lut_x", bus.lut_x, m_sh[5:0]);
        if (m_cnt == lit_sel) begin
          chk("lit_lut_x", bus.lut_x, lit_x);
          chk("lit_bank_z", bus.lut_z, lit_z);
        end
      end
      default: begin
        chk("done_out_valid", bus.out_valid, 1);
        chk("done_in_ready", bus.in_ready, 0);
        chk("done_busy", bus.busy, 1);
        chk("done_lut_sel", bus.lut_sel, 0);
        chk("done_err", bus.err, m_err);
        if (m_known) chk("done_out_res", bus.out_res, m_res);
        if (lit_res >= 0) chk("lit_out_res", bus.out_res, lit_res);
        if (lit_err >= 0) chk("lit_err", bus.err, lit_err);
      end
    endcase
    if (rst_n) begin
      case (m_st)
        0: if (bus.in_valid) begin
          m_op = bus.in_data; m_st = 1; m_cnt = 0; m_err = 0;
          m_res = mod_ref(bus.in_data); m_known = (force_k < 0);
        end
        1: begin
          if (int'(bus.lut_z) >= M) m_err = 1;
          m_cnt++;
          if (m_cnt == NCH) m_st = 2;
        end
        default: if (bus.out_ready) m_st = 0;
      endcase
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      if (++n > 300) begin
        $display("FAIL wait_in_ready: timed out, in_ready still %0d", bus.in_ready);
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  // One operand: capture, random out_ready while running, hold DONE `hold` cycles
  task automatic run_op(logic [IN_W-1:0] d, int hold, int lres, int lerr,
                        int lsel, int lx, int lz, int fk);
    int n = 0;
    wait_ready();
    @(posedge clk); #1;
    lit_res = lres; lit_err = lerr; lit_sel = lsel; lit_x = lx; lit_z = lz; force_k = fk;
    bus.in_valid = 1'b1; bus.in_data = d; bus.out_ready = 1'($urandom);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = rnd_op();
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (n > 200) begin
        $display("FAIL wait_out_valid: timed out, out_valid still %0d", bus.out_valid);
        $fatal(1);
      end
      @(posedge clk); #1;
      n++;
      bus.out_ready = (n < 80) ? 1'($urandom) : (hold == 0);
    end
    #1;
    if (hold > 0) begin
      bus.in_valid = 1'b1; bus.in_data = rnd_op();
    end
    repeat (hold) @(posedge clk);
    #1;
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    force_k = -1; lit_res = -1; lit_err = -1; lit_sel = -1;
  endtask

  initial begin
    logic [IN_W-1:0] v;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(500'd1,    0, 1,    0, 0, 1, 1, -1);
    run_op(500'd2011, 0, 0,   -1, -1, 0, 0, -1);
    run_op(500'd2010, 1, 2010, -1, -1, 0, 0, -1);
    run_op(500'd4022, 0, 0,   -1, -1, 0, 0, -1);
    v = '0; v[60] = 1'b1;
    run_op(v, 0, 850, 0, 10, 1, 850, -1);
    run_op(rnd_op(), 20, -1, -1, -1, 0, 0, -1);
    run_op(rnd_op(), 0, -1, -1, -1, 0, 0, -1);
    run_op(rnd_op(), 2, -1, 1, -1, 0, 0, 5);
    run_op(rnd_op(), 0, -1, 0, -1, 0, 0, -1);
    v = '1;
    run_op(v, 0, -1, -1, 83, 3, bank_fn(83, 3), -1);

    // Abort mid-run: reset lands just after the edge presenting chunk 40
    wait_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = rnd_op();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (bus.lut_sel != 7'd39) begin
        if (++n > 200) begin
          $display("FAIL wait_sel39: timed out, lut_sel %0d", bus.lut_sel);
          $fatal(1);
        end
        @(negedge clk);
      end
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(500'd12345, 0, 12345 % M, 0, -1, 0, 0, -1);

    for (int i = 0; i < 20; i++)
      run_op(rnd_op(), int'($urandom_range(0, 3)), -1, -1, -1, 0, 0, -1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
